// File: rtl/hazard_filter.sv
// hazard_filter
//   Debounce / glitch filter placed directly after the hazard-corrected
//   3-input combinational block. The raw block output is synchronised and
//   must hold a new level for STABLE_CYCLES consecutive enabled samples
//   before it reaches dout. Every candidate transition that collapses early
//   (static hazard or runt pulse) is reported as a one-cycle glitch pulse and
//   counted in a saturating counter.
//
// Build option:
//   HAZARD_FILTER_SYNC_EN defined   : 2-flop input synchroniser,
//                                     latency 2+STABLE_CYCLES edges
//   HAZARD_FILTER_SYNC_EN undefined : single capture flop,
//                                     latency 1+STABLE_CYCLES edges
//
// Parameters:
//   STABLE_CYCLES  samples a new level must persist (1..15)
//   CNT_W          width of the glitch counter
//
// Ports:
//   clk         system clock, rising edge
//   rst         synchronous active-high reset
//   din         raw combinational output (asynchronous to clk)
//   en          sampling enable; 0 freezes filter state, synchroniser still runs
//   clr_cnt     synchronous clear of glitch_cnt / sat
//   dout        filtered level
//   rise, fall  one-cycle pulses on dout 0->1 / 1->0
//   glitch      one-cycle pulse when a candidate transition aborts
//   glitch_cnt  saturating count of aborted transitions
//   sat         high while glitch_cnt is all ones
module hazard_filter #(
  parameter int STABLE_CYCLES = 3,
  parameter int CNT_W         = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             din,
  input  logic             en,
  input  logic             clr_cnt,
  output logic             dout,
  output logic             rise,
  output logic             fall,
  output logic             glitch,
  output logic [CNT_W-1:0] glitch_cnt,
  output logic             sat
);

`ifdef HAZARD_FILTER_SYNC_EN
  localparam int SYNC_DEPTH = 2;
`else
  localparam int SYNC_DEPTH = 1;
`endif

  localparam logic [3:0] STABLE_LIM = 4'(STABLE_CYCLES);

  typedef enum logic {STABLE, CANDIDATE} state_t;

  // ---------------------------------------------------------------- capture
  logic [SYNC_DEPTH-1:0] sync_reg;
  logic                  din_s;

  generate
    for (genvar gi = 0; gi < SYNC_DEPTH; gi++) begin : g_sync
      always_ff @(posedge clk) begin
        if (rst) begin
          sync_reg[gi] <= 1'b0;
        end else if (gi == 0) begin
          sync_reg[gi] <= din;
        end else begin
          sync_reg[gi] <= sync_reg[(gi == 0) ? 0 : gi-1];
        end
      end
    end
  endgenerate

  assign din_s = sync_reg[SYNC_DEPTH-1];

  // ------------------------------------------------------------ filter state
  state_t           state_reg,  state_next;
  logic [3:0]       run_reg,    run_next;
  logic             dout_reg,   dout_next;
  logic             rise_reg,   rise_next;
  logic             fall_reg,   fall_next;
  logic             glitch_reg, glitch_next;
  logic [CNT_W-1:0] cnt_reg,    cnt_next;
  logic             sat_reg,    sat_next;
  logic             abort;
  logic [3:0]       run_inc;

  assign run_inc = run_reg + 4'd1;

  always_comb begin
    state_next  = state_reg;
    run_next    = run_reg;
    dout_next   = dout_reg;
    rise_next   = 1'b0;
    fall_next   = 1'b0;
    glitch_next = 1'b0;
    abort       = 1'b0;

    if (en) begin
      case (state_reg)
        STABLE: begin
          if (din_s != dout_reg) begin
            if (STABLE_CYCLES == 1) begin
              // A single differing sample is already enough: no candidate phase.
              dout_next = din_s;
              rise_next = din_s;
              fall_next = ~din_s;
            end else begin
              state_next = CANDIDATE;
              run_next   = 4'd1;
            end
          end
        end
        CANDIDATE: begin
          if (din_s == dout_reg) begin
            // Input fell back before qualifying: hazard / runt pulse.
            abort       = 1'b1;
            glitch_next = 1'b1;
            run_next    = 4'd0;
            state_next  = STABLE;
          end else if (run_inc == STABLE_LIM) begin
            dout_next  = din_s;
            rise_next  = din_s;
            fall_next  = ~din_s;
            run_next   = 4'd0;
            state_next = STABLE;
          end else begin
            run_next = run_inc;
          end
        end
        default: begin
          state_next = STABLE;
          run_next   = 4'd0;
        end
      endcase
    end

    // A clear coinciding with an abort keeps that abort in the count.
    cnt_next = cnt_reg;
    if (clr_cnt) begin
      cnt_next = abort ? CNT_W'(1) : '0;
    end else if (abort && (cnt_reg != '1)) begin
      cnt_next = cnt_reg + CNT_W'(1);
    end
    sat_next = &cnt_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= STABLE;
      run_reg    <= 4'd0;
      dout_reg   <= 1'b0;
      rise_reg   <= 1'b0;
      fall_reg   <= 1'b0;
      glitch_reg <= 1'b0;
      cnt_reg    <= '0;
      sat_reg    <= 1'b0;
    end else begin
      state_reg  <= state_next;
      run_reg    <= run_next;
      dout_reg   <= dout_next;
      rise_reg   <= rise_next;
      fall_reg   <= fall_next;
      glitch_reg <= glitch_next;
      cnt_reg    <= cnt_next;
      sat_reg    <= sat_next;
    end
  end

  assign dout       = dout_reg;
  assign rise       = rise_reg;
  assign fall       = fall_reg;
  assign glitch     = glitch_reg;
  assign glitch_cnt = cnt_reg;
  assign sat        = sat_reg;

endmodule

// File: tb/tb_hazard_filter.sv
// Directed testbench for hazard_filter (STABLE_CYCLES=3, CNT_W=2).
// Inputs change 1 time unit after a rising edge; outputs are sampled at
// the same point, so each tick() observes the result of exactly one edge.
module tb_hazard_filter;

  localparam int S     = 3;
  localparam int CNT_W = 2;
`ifdef HAZARD_FILTER_SYNC_EN
  localparam int SYNC = 2;
`else
  localparam int SYNC = 1;
`endif
  localparam int LAT = SYNC + S;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             din = 1'b0;
  logic             en = 1'b1;
  logic             clr_cnt = 1'b0;
  logic             dout, rise, fall, glitch, sat;
  logic [CNT_W-1:0] glitch_cnt;

  int pass_cnt  = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  hazard_filter #(.STABLE_CYCLES(S), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .din(din), .en(en), .clr_cnt(clr_cnt),
    .dout(dout), .rise(rise), .fall(fall), .glitch(glitch),
    .glitch_cnt(glitch_cnt), .sat(sat)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reset with din=1 held; dout must rise exactly LAT edges after release.
  task automatic test_reset();
    rst = 1'b1; din = 1'b1; en = 1'b1; clr_cnt = 1'b0;
    tick(); tick();
    total_cnt++;
    if ({dout, rise, fall, glitch, glitch_cnt, sat} !== '0)
      $display("FAIL reset_outputs got=%b exp=0", {dout, rise, fall, glitch, glitch_cnt, sat});
    else pass_cnt++;
    rst = 1'b0;
    for (int i = 1; i <= LAT; i++) begin
      tick();
      total_cnt++;
      if ({dout, rise} !== ((i == LAT) ? 2'b11 : 2'b00))
        $display("FAIL reset_release edge=%0d dout/rise got=%b exp=%b", i, {dout, rise}, (i == LAT) ? 2'b11 : 2'b00);
      else pass_cnt++;
    end
    tick();
    total_cnt++;
    if ({dout, rise, glitch_cnt} !== {2'b10, 2'd0})
      $display("FAIL rise_one_cycle dout/rise/cnt got=%b exp=1000", {dout, rise, glitch_cnt});
    else pass_cnt++;
    $display("test_reset done: dout=%b cnt=%0d", dout, glitch_cnt);
  endtask

  // Static-1 hazard: din low for one clock; dout holds, one glitch, cnt=1.
  task automatic test_hazard();
    int g = 0;
    int bad = 0;
    din = 1'b0; tick(); din = 1'b1;
    if (glitch) g++;
    for (int i = 0; i < LAT + 3; i++) begin
      tick();
      if (glitch) g++;
      if (dout !== 1'b1 || fall || rise) bad++;
    end
    total_cnt++;
    if (bad != 0) $display("FAIL hazard_dout_hold bad_edges=%0d exp=0", bad); else pass_cnt++;
    total_cnt++;
    if (g != 1) $display("FAIL hazard_glitch_pulses got=%0d exp=1", g); else pass_cnt++;
    total_cnt++;
    if (glitch_cnt !== 2'd1) $display("FAIL hazard_cnt got=%0d exp=1", glitch_cnt); else pass_cnt++;
    $display("test_hazard done: glitches=%0d cnt=%0d", g, glitch_cnt);
  endtask

  // Pulse of exactly S clocks passes through: fall at edge LAT, rise S later.
  task automatic test_min_pulse();
    int fall_at = -1;
    int rise_at = -1;
    int nf = 0, nr = 0, g = 0;
    din = 1'b0;
    for (int i = 1; i <= LAT + 2*S + 4; i++) begin
      tick();
      if (i == S) din = 1'b1;
      if (fall) begin nf++; fall_at = i; end
      if (rise) begin nr++; rise_at = i; end
      if (glitch) g++;
    end
    total_cnt++;
    if (fall_at != LAT || nf != 1) $display("FAIL pulse_fall edge=%0d count=%0d exp_edge=%0d exp_count=1", fall_at, nf, LAT); else pass_cnt++;
    total_cnt++;
    if (rise_at - fall_at != S || nr != 1) $display("FAIL pulse_rise gap=%0d count=%0d exp_gap=%0d exp_count=1", rise_at - fall_at, nr, S); else pass_cnt++;
    total_cnt++;
    if (g != 0 || glitch_cnt !== 2'd1 || dout !== 1'b1) $display("FAIL pulse_no_glitch g=%0d cnt=%0d dout=%b exp 0/1/1", g, glitch_cnt, dout); else pass_cnt++;
    $display("test_min_pulse done: fall@%0d rise@%0d", fall_at, rise_at);
  endtask

  // Clear, then 5 hazards with a 2-bit counter: 1,2,3,3,3 and sat from the 3rd.
  task automatic test_saturate();
    int g = 0;
    logic [CNT_W-1:0] exp_cnt;
    clr_cnt = 1'b1; tick(); clr_cnt = 1'b0;
    total_cnt++;
    if ({glitch_cnt, sat} !== 3'b000) $display("FAIL clr_alone cnt/sat got=%b exp=000", {glitch_cnt, sat}); else pass_cnt++;
    for (int k = 1; k <= 5; k++) begin
      din = 1'b0; tick(); din = 1'b1;
      if (glitch) g++;
      for (int i = 0; i < LAT + 2; i++) begin
        tick();
        if (glitch) g++;
      end
      exp_cnt = (k >= 3) ? 2'd3 : CNT_W'(k);
      total_cnt++;
      if ({glitch_cnt, sat} !== {exp_cnt, (k >= 3)})
        $display("FAIL saturate k=%0d cnt/sat got=%0d/%b exp=%0d/%b", k, glitch_cnt, sat, exp_cnt, (k >= 3));
      else pass_cnt++;
      $display("saturate hazard %0d: cnt=%0d sat=%b", k, glitch_cnt, sat);
    end
    total_cnt++;
    if (g != 5) $display("FAIL saturate_pulses got=%0d exp=5", g); else pass_cnt++;
  endtask

  // Freeze mid-candidate (run_cnt=2); dout falls on the first enabled edge.
  task automatic test_en_freeze();
    int bad = 0;
    din = 1'b0;
    for (int i = 0; i < SYNC + 2; i++) begin
      tick();
      if (dout !== 1'b1 || fall) bad++;
    end
    en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (dout !== 1'b1 || fall || rise || glitch) bad++;
    end
    total_cnt++;
    if (bad != 0) $display("FAIL en_freeze_hold bad_edges=%0d exp=0", bad); else pass_cnt++;
    en = 1'b1;
    tick();
    total_cnt++;
    if ({dout, fall, glitch} !== 3'b010) $display("FAIL en_resume dout/fall/glitch got=%b exp=010", {dout, fall, glitch}); else pass_cnt++;
    tick();
    total_cnt++;
    if ({dout, fall} !== 2'b00) $display("FAIL en_fall_one_cycle got=%b exp=00", {dout, fall}); else pass_cnt++;
    $display("test_en_freeze done: dout=%b", dout);
  endtask

  // clr_cnt on the abort edge with cnt saturated -> cnt=1, sat=0.
  task automatic test_clr_abort();
    din = 1'b1; tick(); din = 1'b0;
    for (int i = 0; i < SYNC; i++) tick();
    clr_cnt = 1'b1;
    tick();
    clr_cnt = 1'b0;
    total_cnt++;
    if ({glitch, glitch_cnt, sat, dout} !== {1'b1, 2'd1, 1'b0, 1'b0})
      $display("FAIL clr_with_abort glitch/cnt/sat/dout got=%b exp=10100", {glitch, glitch_cnt, sat, dout});
    else pass_cnt++;
    $display("test_clr_abort done: cnt=%0d sat=%b", glitch_cnt, sat);
  endtask

  // Reset during CANDIDATE: everything clears, no glitch is reported.
  task automatic test_reset_mid();
    int g = 0;
    tick(); tick();
    din = 1'b1;
    for (int i = 0; i < SYNC + 1; i++) tick();
    rst = 1'b1;
    tick();
    total_cnt++;
    if ({dout, rise, fall, glitch, glitch_cnt, sat} !== '0)
      $display("FAIL reset_mid_outputs got=%b exp=0", {dout, rise, fall, glitch, glitch_cnt, sat});
    else pass_cnt++;
    rst = 1'b0; din = 1'b0;
    for (int i = 0; i < LAT + 2; i++) begin
      tick();
      if (glitch || dout || rise) g++;
    end
    total_cnt++;
    if (g != 0) $display("FAIL reset_mid_no_glitch bad_edges=%0d exp=0", g); else pass_cnt++;
    $display("test_reset_mid done");
  endtask

  initial begin
    test_reset();
    test_hazard();
    test_min_pulse();
    test_saturate();
    test_en_freeze();
    test_clr_abort();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
